// File: rtl/misr_multich_periph_if.sv
// Register bus between the AXI-to-register bridge and the MISR peripheral.
// The bridge drives the request side. The peripheral returns combinational read data.
interface misr_multich_periph_if #(
   parameter int NBIT_DATA = 64,
   parameter int NBIT_ADDR = 64
);
   logic                 re;
   logic                 we;
   logic [NBIT_ADDR-1:0] addr;
   logic [NBIT_DATA-1:0] wdata;
   logic [NBIT_DATA-1:0] rdata;

   modport master (output re, output we, output addr, output wdata, input rdata);
   modport slave  (input re, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/misr_multich_periph.sv
// Multi-channel MISR signature unit.
// N_CH signature registers share one feedback polynomial and one sample counter.
// A start/run/done sequencer compresses exactly LENGTH samples.
// At the end it raises a sticky done flag and an optional level interrupt.
module misr_multich_periph #(
   parameter int                   NBIT_DATA  = 64,
   parameter int                   NBIT_ADDR  = 64,
   parameter int                   N_CH       = 4,
   parameter int                   NBIT_CNT   = 32,
   parameter logic [NBIT_ADDR-1:0] START_ADDR = NBIT_ADDR'(2**25)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   misr_multich_periph_if.slave      bus,
   input  logic                      sample_vld_i,
   input  logic [N_CH*NBIT_DATA-1:0] data_ch_i,
   output logic                      irq_o
);

   localparam int ALIGN = $clog2(NBIT_DATA / 8);
   localparam int IDX_W = NBIT_ADDR - ALIGN;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [NBIT_CNT-1:0]  count_q, count_d;
   logic [NBIT_CNT-1:0]  length_q, length_d;
   logic [NBIT_DATA-1:0] coeff_q, coeff_d;
   logic                 irq_en_q, irq_en_d;
   logic [N_CH-1:0]      ch_en_q, ch_en_d;
   logic [NBIT_DATA-1:0] sig_q [N_CH];
   logic [NBIT_DATA-1:0] sig_d [N_CH];

   logic [NBIT_ADDR-1:0] off;
   logic [IDX_W-1:0]     idx;
   logic                 hit;
   logic                 ctrl_wr, coeff_wr, len_wr, start_cmd, clear_cmd;
   logic                 busy, done;
   logic [NBIT_DATA-1:0] status_w;
   logic [NBIT_DATA-1:0] rdata_c;

   // One MISR shift: multiply by x modulo the polynomial, then fold in the new sample.
   function automatic logic [NBIT_DATA-1:0] misr_step(input logic [NBIT_DATA-1:0] sig,
                                                      input logic [NBIT_DATA-1:0] coeff,
                                                      input logic [NBIT_DATA-1:0] din);
      return {sig[NBIT_DATA-2:0], 1'b0} ^ (sig[NBIT_DATA-1] ? coeff : '0) ^ din;
   endfunction

   // Register decode. Only word-aligned addresses inside the map are recognised.
   assign off       = bus.addr - START_ADDR;
   assign idx       = off[NBIT_ADDR-1:ALIGN];
   assign hit       = (bus.addr >= START_ADDR) && (off[ALIGN-1:0] == '0) &&
                      (idx < IDX_W'(4 + N_CH));
   assign ctrl_wr   = bus.we && hit && (idx == IDX_W'(0));
   assign coeff_wr  = bus.we && hit && (idx == IDX_W'(1));
   assign len_wr    = bus.we && hit && (idx == IDX_W'(2));
   assign start_cmd = ctrl_wr && bus.wdata[0];
   assign clear_cmd = ctrl_wr && bus.wdata[1];

   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign irq_o = done && irq_en_q;

   // Next-state logic. CLEAR beats START, and both override any sample in the same cycle.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      length_d = length_q;
      coeff_d  = coeff_q;
      irq_en_d = irq_en_q;
      ch_en_d  = ch_en_q;
      sig_d    = sig_q;
      if (ctrl_wr) begin
         irq_en_d = bus.wdata[2];
         ch_en_d  = bus.wdata[16 +: N_CH];
      end
      if (coeff_wr && !busy) coeff_d = bus.wdata;
      if (len_wr && !busy) length_d = bus.wdata[NBIT_CNT-1:0];
      if (clear_cmd) begin
         state_d = IDLE;
         count_d = '0;
         for (int k = 0; k < N_CH; k++) sig_d[k] = '0;
      end else if (start_cmd) begin
         state_d = (length_q == '0) ? DONE : RUN;
         count_d = '0;
         for (int k = 0; k < N_CH; k++) sig_d[k] = '0;
      end else if (busy && sample_vld_i) begin
         for (int k = 0; k < N_CH; k++)
            if (ch_en_q[k]) sig_d[k] = misr_step(sig_q[k], coeff_q, data_ch_i[k*NBIT_DATA +: NBIT_DATA]);
         count_d = count_q + NBIT_CNT'(1);
         if (count_d == length_q) state_d = DONE;
      end
   end

   // Sequencer state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Configuration, counter and signature registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q  <= '0;
         length_q <= '0;
         coeff_q  <= '0;
         irq_en_q <= 1'b0;
         ch_en_q  <= '0;
         for (int k = 0; k < N_CH; k++) sig_q[k] <= '0;
      end else begin
         count_q  <= count_d;
         length_q <= length_d;
         coeff_q  <= coeff_d;
         irq_en_q <= irq_en_d;
         ch_en_q  <= ch_en_d;
         sig_q    <= sig_d;
      end
   end

   // STATUS carries the sample count only when the register is wide enough to hold it.
   if (NBIT_DATA >= 32 + NBIT_CNT) begin : g_status_cnt
      // Status word with the sample count in the upper half.
      always_comb begin
         status_w                 = '0;
         status_w[32 +: NBIT_CNT] = count_q;
         status_w[1:0]            = {done, busy};
      end
   end else begin : g_status_flags
      // Status word with flags only.
      always_comb begin
         status_w      = '0;
         status_w[1:0] = {done, busy};
      end
   end

   // Combinational read mux. Read data is zero unless this is a pure read of a mapped register.
   always_comb begin
      rdata_c = '0;
      if (bus.re && !bus.we && hit) begin
         case (idx)
            IDX_W'(0): begin
               rdata_c[2]           = irq_en_q;
               rdata_c[16 +: N_CH]  = ch_en_q;
            end
            IDX_W'(1): rdata_c = coeff_q;
            IDX_W'(2): rdata_c = NBIT_DATA'(length_q);
            IDX_W'(3): rdata_c = status_w;
            default: begin
               for (int k = 0; k < N_CH; k++)
                  if (idx == IDX_W'(4 + k)) rdata_c = sig_q[k];
            end
         endcase
      end
   end

   assign bus.rdata = rdata_c;

endmodule

// File: tb/tb_misr_multich_periph.sv
// Directed bench for misr_multich_periph.
// A behavioural model tracks the expected register contents every cycle.
// Literal expectations pin the model at the key points.
module tb_misr_multich_periph;

   localparam int          ND   = 64;
   localparam int          NA   = 64;
   localparam int          NCH  = 4;
   localparam int          NC   = 32;
   localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
   localparam logic [63:0] A_CTRL  = BASE;
   localparam logic [63:0] A_COEFF = BASE + 64'd8;
   localparam logic [63:0] A_LEN   = BASE + 64'd16;
   localparam logic [63:0] A_STAT  = BASE + 64'd24;
   localparam logic [63:0] A_SIG0  = BASE + 64'd32;
   localparam logic [63:0] A_SIG1  = BASE + 64'd40;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               vld;
   logic [NCH*ND-1:0]  dch;
   logic               irq;
   int                 n_tests = 0;
   int                 n_fail  = 0;

   misr_multich_periph_if #(.NBIT_DATA(ND), .NBIT_ADDR(NA)) bus ();

   misr_multich_periph #(
      .NBIT_DATA(ND), .NBIT_ADDR(NA), .N_CH(NCH), .NBIT_CNT(NC), .START_ADDR(BASE)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus), .sample_vld_i(vld), .data_ch_i(dch), .irq_o(irq)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          m_busy, m_done, m_irq_en;
   bit [NCH-1:0] m_ch_en;
   bit [63:0]   m_coeff;
   bit [31:0]   m_len, m_cnt;
   bit [63:0]   m_sig [NCH];

   function automatic bit [63:0] ref_step(bit [63:0] s, bit [63:0] c, bit [63:0] d);
      return (s << 1) ^ (s[63] ? c : 64'd0) ^ d;
   endfunction

   task automatic m_clear_run();
      m_cnt = 0;
      for (int k = 0; k < NCH; k++) m_sig[k] = 0;
   endtask

   task automatic m_step();
      bit was_busy;
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_irq_en = 0; m_ch_en = 0;
         m_coeff = 0; m_len = 0; m_clear_run();
         return;
      end
      was_busy = m_busy;
      if (m_busy && vld) begin
         for (int k = 0; k < NCH; k++)
            if (m_ch_en[k]) m_sig[k] = ref_step(m_sig[k], m_coeff, dch[k*ND +: ND]);
         m_cnt++;
         if (m_cnt == m_len) begin m_busy = 0; m_done = 1; end
      end
      if (bus.we && !was_busy && bus.addr == A_COEFF) m_coeff = bus.wdata;
      if (bus.we && !was_busy && bus.addr == A_LEN)   m_len   = bus.wdata[31:0];
      if (bus.we && bus.addr == A_CTRL) begin
         m_irq_en = bus.wdata[2];
         m_ch_en  = bus.wdata[16 +: NCH];
         if (bus.wdata[1]) begin
            m_clear_run(); m_busy = 0; m_done = 0;
         end else if (bus.wdata[0]) begin
            m_clear_run();
            m_busy = (m_len != 0);
            m_done = (m_len == 0);
         end
      end
   endtask

   function automatic logic [63:0] m_read(logic [63:0] a, logic re, logic we);
      logic [63:0] o;
      if (!re || we || a < BASE) return 64'd0;
      o = a - BASE;
      if (o % 8 != 0) return 64'd0;
      o = o / 8;
      if (o == 0) return (64'(m_ch_en) << 16) | (64'(m_irq_en) << 2);
      if (o == 1) return m_coeff;
      if (o == 2) return 64'(m_len);
      if (o == 3) return {m_cnt, 30'd0, m_done, m_busy};
      if (o < 4 + NCH) return m_sig[o-4];
      return 64'd0;
   endfunction

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of the DUT outputs against the model.
   always @(negedge clk) begin
      check("irq_model", {63'd0, irq}, {63'd0, m_done & m_irq_en});
      check("rdata_model", bus.rdata, m_read(bus.addr, bus.re, bus.we));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic set_bus(logic re, logic we, logic [63:0] a, logic [63:0] d);
      bus.re = re; bus.we = we; bus.addr = a; bus.wdata = d; vld = 1'b0;
   endtask

   task automatic wr(logic [63:0] a, logic [63:0] d);
      set_bus(1'b0, 1'b1, a, d);
      tick();
   endtask

   task automatic rd(logic [63:0] a, logic [63:0] exp, string nm);
      set_bus(1'b1, 1'b0, a, 64'd0);
      @(negedge clk);
      check(nm, bus.rdata, exp);
      tick();
   endtask

   task automatic chk_irq(logic exp, string nm);
      set_bus(1'b0, 1'b0, A_CTRL, 64'd0);
      @(negedge clk);
      check(nm, {63'd0, irq}, {63'd0, exp});
      tick();
   endtask

   task automatic smp(logic v, logic [63:0] d0, logic [63:0] d1);
      set_bus(1'b0, 1'b0, A_CTRL, 64'd0);
      vld = v;
      dch = '0;
      dch[0 +: ND]  = d0;
      dch[ND +: ND] = d1;
      dch[2*ND +: ND] = 64'hDEAD_BEEF;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      dch   = '0;
      set_bus(1'b1, 1'b1, A_CTRL, '1);
      vld   = 1'b1;
      // reset with bus activity
      tick();
      wr(A_COEFF, 64'hFFFF);
      rd(A_STAT, 64'd0, "rst_status");
      chk_irq(1'b0, "rst_irq");
      rst_n = 1'b1;
      rd(A_COEFF, 64'd0, "coeff_after_rst");
      rd(A_STAT, 64'd0, "status_after_rst");
      rd(BASE + 64'd64, 64'd0, "unmapped");
      rd(BASE + 64'd4, 64'd0, "misaligned");

      // basic compression on channel 0
      wr(A_COEFF, 64'h1B);
      wr(A_LEN, 64'd3);
      wr(A_CTRL, 64'h1_0001);
      rd(A_CTRL, 64'h1_0000, "ctrl_selfclr");
      rd(A_STAT, 64'd1, "busy");
      smp(1'b1, 64'h1, 64'h55);
      smp(1'b1, 64'h0, 64'h55);
      smp(1'b1, 64'h0, 64'h55);
      rd(A_STAT, 64'h3_0000_0002, "t2_status");
      rd(A_SIG0, 64'h4, "t2_sig0");
      rd(A_SIG1, 64'h0, "t2_sig1_disabled");
      smp(1'b1, 64'hFF, 64'h0);
      rd(A_SIG0, 64'h4, "done_frozen");

      // feedback path
      wr(A_LEN, 64'd2);
      wr(A_CTRL, 64'h1_0001);
      smp(1'b1, 64'h8000_0000_0000_0000, 64'h0);
      smp(1'b1, 64'h0, 64'h0);
      rd(A_SIG0, 64'h1B, "feedback");

      // zero length and interrupt
      wr(A_LEN, 64'd0);
      wr(A_CTRL, 64'h1_0005);
      rd(A_STAT, 64'd2, "len0_done");
      chk_irq(1'b1, "irq_set");
      rd(A_SIG0, 64'd0, "len0_sig0");
      chk_irq(1'b1, "irq_sticky");
      wr(A_CTRL, 64'h1_0006);
      chk_irq(1'b0, "irq_cleared");

      // mid-run CLEAR and COEFF write while busy
      wr(A_LEN, 64'd5);
      wr(A_CTRL, 64'h3_0001);
      smp(1'b1, 64'h1, 64'h2);
      smp(1'b1, 64'h1, 64'h2);
      wr(A_COEFF, 64'hFFFF);
      rd(A_COEFF, 64'h1B, "coeff_locked");
      rd(A_STAT, 64'h2_0000_0001, "mid_status");
      wr(A_CTRL, 64'h3_0002);
      smp(1'b1, 64'h1, 64'h2);
      smp(1'b1, 64'h1, 64'h2);
      rd(A_STAT, 64'd0, "clear_status");
      rd(A_SIG0, 64'd0, "clear_sig0");

      // gaps in the strobe
      wr(A_LEN, 64'd3);
      wr(A_CTRL, 64'h3_0001);
      smp(1'b1, 64'h1, 64'h10);
      smp(1'b0, 64'hFF, 64'hFF);
      smp(1'b1, 64'h1, 64'h10);
      rd(A_STAT, 64'h2_0000_0001, "gap_status2");
      smp(1'b1, 64'h1, 64'h10);
      rd(A_STAT, 64'h3_0000_0002, "gap_done");
      rd(A_SIG0, 64'h7, "gap_sig0");
      rd(A_SIG1, 64'h70, "gap_sig1");
      wr(A_CTRL, 64'h3_0003);
      rd(A_STAT, 64'd0, "start_clear_idle");
      rd(A_SIG1, 64'd0, "start_clear_sig1");

      // simultaneous read and write
      set_bus(1'b1, 1'b1, A_LEN, 64'd7);
      @(negedge clk);
      check("rw_both", bus.rdata, 64'd0);
      tick();
      rd(A_LEN, 64'd7, "rw_write_taken");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
